// File: rtl/switch_egress_collector.sv
// switch_egress_collector
// Samples the per-port output bus of very_simple_switch, buffers each port's
// words in a small FIFO, and drains them round-robin onto one valid/ready
// stream tagged with the source port. Per-port receive counters and sticky
// drop flags are kept for debug and statistics.

module switch_egress_collector #(
  parameter int OUTPUT_QTY = 8,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [OUTPUT_QTY-1:0]                 data_out_valid,
  input  logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [DATA_WIDTH-1:0]                 m_data,
  output logic [$clog2(OUTPUT_QTY)-1:0]         m_port,
  output logic [OUTPUT_QTY-1:0][15:0]           rx_count,
  output logic [OUTPUT_QTY-1:0]                 drop_flag,
  input  logic                                  clear_stats
);

  localparam int PORT_W = $clog2(OUTPUT_QTY);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      COUNT_MAX  = 16'hFFFF;

  // Per-port FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] fifo_mem [OUTPUT_QTY][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr   [OUTPUT_QTY];
  logic [PTR_W-1:0]      rd_ptr   [OUTPUT_QTY];
  logic [CNT_W-1:0]      level    [OUTPUT_QTY];

  logic [OUTPUT_QTY-1:0] non_empty;
  logic [OUTPUT_QTY-1:0] full;
  logic [OUTPUT_QTY-1:0] push;
  logic [OUTPUT_QTY-1:0] pop;

  // Arbitration state
  logic [PORT_W-1:0]     rr_ptr;
  logic [PORT_W-1:0]     grant;
  logic [PORT_W-1:0]     cand;
  logic                  grant_found;
  logic                  out_free;
  logic [DATA_WIDTH-1:0] head_data;

  // The output register can take a new word when it is empty or being consumed
  assign out_free = !m_valid || m_ready;

  // Derive empty/full status from each FIFO's occupancy count
  always_comb begin
    non_empty = '0;
    full      = '0;
    for (int p = 0; p < OUTPUT_QTY; p++) begin
      non_empty[p] = (level[p] != '0);
      full[p]      = (level[p] == FULL_LEVEL);
    end
  end

  // Round-robin search starting at rr_ptr; walking backwards lets the
  // nearest non-empty port overwrite farther candidates
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int i = OUTPUT_QTY - 1; i >= 0; i--) begin
      cand = rr_ptr + PORT_W'(i);
      if (non_empty[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  // Pop only the granted FIFO when the output register is free; a full FIFO
  // still accepts a push when it is popped on the same edge
  always_comb begin
    pop  = '0;
    push = '0;
    for (int p = 0; p < OUTPUT_QTY; p++) begin
      pop[p]  = out_free && grant_found && (grant == PORT_W'(p));
      push[p] = data_out_valid[p] && (!full[p] || pop[p]);
    end
    head_data = fifo_mem[grant][rd_ptr[grant]];
  end

  // FIFO data storage; contents need no reset because the pointers do
  always_ff @(posedge clk) begin
    for (int p = 0; p < OUTPUT_QTY; p++) begin
      if (push[p]) begin
        fifo_mem[p][wr_ptr[p]] <= data_out[p];
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < OUTPUT_QTY; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        level[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < OUTPUT_QTY; p++) begin
        if (push[p]) begin
          wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
        end
        if (pop[p]) begin
          rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
        end
        case ({push[p], pop[p]})
          2'b10:   level[p] <= level[p] + CNT_W'(1);
          2'b01:   level[p] <= level[p] - CNT_W'(1);
          default: level[p] <= level[p];
        endcase
      end
    end
  end

  // Output register and round-robin pointer; holds steady under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_port  <= '0;
      rr_ptr  <= '0;
    end else if (out_free) begin
      m_valid <= grant_found;
      if (grant_found) begin
        m_data <= head_data;
        m_port <= grant;
        rr_ptr <= grant + PORT_W'(1);
      end
    end
  end

  // Receive counters and sticky drop flags; clearing beats any update
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_count  <= '0;
      drop_flag <= '0;
    end else begin
      for (int p = 0; p < OUTPUT_QTY; p++) begin
        if (clear_stats) begin
          rx_count[p]  <= '0;
          drop_flag[p] <= 1'b0;
        end else if (data_out_valid[p]) begin
          if (rx_count[p] != COUNT_MAX) begin
            rx_count[p] <= rx_count[p] + 16'd1;
          end
          if (!push[p]) begin
            drop_flag[p] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_egress_collector.sv
// tb_switch_egress_collector
// Directed scenarios followed by a randomized phase, every cycle compared
// against a queue-based behavioural model of the collector.

module tb_switch_egress_collector;

  localparam int Q = 8;
  localparam int D = 4;
  localparam int W = 64;

  logic                clk;
  logic                reset;
  logic [Q-1:0]        data_out_valid;
  logic [Q-1:0][W-1:0] data_out;
  logic                m_valid;
  logic                m_ready;
  logic [W-1:0]        m_data;
  logic [2:0]          m_port;
  logic [Q-1:0][15:0]  rx_count;
  logic [Q-1:0]        drop_flag;
  logic                clear_stats;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [W-1:0] mq [Q][$];
  int           cnt [Q];
  bit           drp [Q];
  bit           mv;
  logic [W-1:0] md;
  logic [2:0]   mp;
  int           rr;

  switch_egress_collector #(
    .OUTPUT_QTY(Q),
    .DATA_WIDTH(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_port         (m_port),
    .rx_count       (rx_count),
    .drop_flag      (drop_flag),
    .clear_stats    (clear_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    bit           free;
    int           g;
    int           p;
    logic [W-1:0] head;
    head = '0;
    if (reset) begin
      for (int i = 0; i < Q; i++) begin
        mq[i].delete();
        cnt[i] = 0;
        drp[i] = 1'b0;
      end
      mv = 1'b0;
      md = '0;
      mp = '0;
      rr = 0;
      return;
    end
    free = !mv || m_ready;
    g = -1;
    if (free) begin
      for (int k = 0; k < Q; k++) begin
        p = (rr + k) % Q;
        if (mq[p].size() != 0) begin
          g = p;
          break;
        end
      end
    end
    if (g >= 0) head = mq[g].pop_front();
    for (int i = 0; i < Q; i++) begin
      if (data_out_valid[i]) begin
        if (cnt[i] < 65535) cnt[i]++;
        if (mq[i].size() < D) mq[i].push_back(data_out[i]);
        else drp[i] = 1'b1;
      end
    end
    if (free) begin
      if (g >= 0) begin
        mv = 1'b1;
        md = head;
        mp = 3'(g);
        rr = (g + 1) % Q;
      end else begin
        mv = 1'b0;
      end
    end
    if (clear_stats) begin
      for (int i = 0; i < Q; i++) begin
        cnt[i] = 0;
        drp[i] = 1'b0;
      end
    end
  endtask

  // Single comparison of a DUT value against a bench-derived expectation
  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare all DUT outputs against the model
  task automatic check_output(input string tag);
    check_val({tag, ".m_valid"}, W'(m_valid), W'(mv));
    if (mv) begin
      check_val({tag, ".m_data"}, m_data, md);
      check_val({tag, ".m_port"}, W'(m_port), W'(mp));
    end
    for (int i = 0; i < Q; i++) begin
      check_val($sformatf("%s.rx_count[%0d]", tag, i), W'(rx_count[i]), W'(16'(cnt[i])));
      check_val($sformatf("%s.drop_flag[%0d]", tag, i), W'(drop_flag[i]), W'(drp[i]));
    end
  endtask

  // One clock edge: update the model at the edge, compare shortly after
  task automatic apply_stimulus(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  task automatic idle_inputs();
    data_out_valid = '0;
    data_out       = '0;
    clear_stats    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m_ready = 1'b0;
    idle_inputs();
    mv = 1'b0; md = '0; mp = '0; rr = 0;
    for (int i = 0; i < Q; i++) begin
      cnt[i] = 0;
      drp[i] = 1'b0;
    end

    // Reset held for 3 edges with random inputs
    $display("[TB] reset with random inputs");
    for (int c = 0; c < 3; c++) begin
      data_out_valid = 8'($urandom);
      for (int i = 0; i < Q; i++) data_out[i] = {$urandom, $urandom};
      m_ready     = 1'($urandom);
      clear_stats = 1'($urandom);
      apply_stimulus("reset");
    end
    check_val("reset.m_data", m_data, '0);
    check_val("reset.m_port", W'(m_port), '0);
    check_val("reset.rx_count", W'(rx_count), '0);
    reset = 1'b0;
    m_ready = 1'b0;
    idle_inputs();
    apply_stimulus("post_reset0");
    apply_stimulus("post_reset1");
    check_val("post_reset.m_valid", W'(m_valid), '0);

    // Single port stream
    $display("[TB] single port");
    m_ready = 1'b1;
    data_out_valid = 8'b0000_0010;
    data_out[1] = 64'd1;
    apply_stimulus("single");
    data_out[1] = 64'd2;
    apply_stimulus("single");
    check_val("single.first_data", m_data, 64'd1);
    check_val("single.first_port", W'(m_port), 64'd1);
    data_out[1] = 64'd3;
    apply_stimulus("single");
    check_val("single.second_data", m_data, 64'd2);
    idle_inputs();
    apply_stimulus("single");
    check_val("single.third_data", m_data, 64'd3);
    apply_stimulus("single");
    check_val("single.drained", W'(m_valid), '0);
    check_val("single.rx_count1", W'(rx_count[1]), 64'd3);

    // All ports for one cycle, starting from a fresh round-robin pointer
    $display("[TB] all ports one cycle");
    reset = 1'b1;
    apply_stimulus("allports_rst");
    reset = 1'b0;
    m_ready = 1'b1;
    data_out_valid = '1;
    for (int i = 0; i < Q; i++) data_out[i] = W'(i);
    apply_stimulus("allports");
    idle_inputs();
    for (int k = 0; k < Q; k++) begin
      apply_stimulus("allports");
      check_val($sformatf("allports.port%0d", k), W'(m_port), W'(k));
      check_val($sformatf("allports.data%0d", k), m_data, W'(k));
    end
    apply_stimulus("allports_end");
    check_val("allports.drained", W'(m_valid), '0);
    for (int i = 0; i < Q; i++) check_val($sformatf("allports.rx%0d", i), W'(rx_count[i]), 64'd1);

    // Overflow under backpressure
    $display("[TB] overflow");
    reset = 1'b1;
    apply_stimulus("overflow_rst");
    reset = 1'b0;
    m_ready = 1'b0;
    data_out_valid = 8'b0000_0010;
    for (int k = 0; k < 6; k++) begin
      data_out[1] = W'(k);
      apply_stimulus("overflow");
    end
    idle_inputs();
    check_val("overflow.drop1", W'(drop_flag[1]), 64'd1);
    check_val("overflow.rx1", W'(rx_count[1]), 64'd6);
    check_val("overflow.held", m_data, 64'd0);
    apply_stimulus("overflow_hold");
    check_val("overflow.still_held", m_data, 64'd0);
    m_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      apply_stimulus("overflow_drain");
      check_val($sformatf("overflow.out%0d", k), m_data, W'(k));
    end
    apply_stimulus("overflow_end");
    check_val("overflow.drained", W'(m_valid), '0);

    // clear_stats on the same edge as a capture
    $display("[TB] clear vs increment");
    clear_stats = 1'b1;
    data_out_valid = 8'b0000_0001;
    data_out[0] = 64'hABC;
    apply_stimulus("clear");
    check_val("clear.rx0", W'(rx_count[0]), '0);
    check_val("clear.drop", W'(drop_flag), '0);
    idle_inputs();
    apply_stimulus("clear_deliver");
    check_val("clear.data", m_data, 64'hABC);
    check_val("clear.valid", W'(m_valid), 64'd1);

    // Reset while words are buffered and the output register is full
    $display("[TB] reset mid-stream");
    apply_stimulus("midrst_idle");
    m_ready = 1'b0;
    data_out_valid = 8'b0000_0100;
    for (int k = 0; k < 4; k++) begin
      data_out[2] = 64'h200 + W'(k);
      apply_stimulus("midrst_fill");
    end
    idle_inputs();
    check_val("midrst.valid_before", W'(m_valid), 64'd1);
    reset = 1'b1;
    apply_stimulus("midrst_reset");
    check_val("midrst.valid_after", W'(m_valid), '0);
    reset = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus("midrst_release");
      check_val("midrst.no_stale", W'(m_valid), '0);
    end

    // Randomized traffic with backpressure, clears and occasional resets
    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) < 2);
      clear_stats = ($urandom_range(0, 99) < 4);
      m_ready     = ($urandom_range(0, 99) < 60);
      data_out_valid = 8'($urandom) & 8'($urandom);
      for (int i = 0; i < Q; i++) data_out[i] = {$urandom, $urandom};
      apply_stimulus("rand");
    end
    reset = 1'b0;
    idle_inputs();
    m_ready = 1'b1;
    for (int c = 0; c < 40; c++) apply_stimulus("rand_drain");
    check_val("rand.drained", W'(m_valid), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
